// File: rtl/ami_resp_buffer.sv
// Per-(app, port) read-response buffer: one circular FIFO per slot, fed from a
// single arbiter response bus and drained by each application's valid/grant handshake.

package ami_pkg;
   localparam int unsigned AMI_APP_BITS  = 1;
   localparam int unsigned AMI_PORT_BITS = 1;
   localparam int unsigned AMI_DATA_W    = 64;
   localparam int unsigned AMI_SIZE_W    = 6;

   typedef struct packed {
      logic                     valid;
      logic [AMI_DATA_W-1:0]    data;
      logic                     channel;
      logic [AMI_PORT_BITS-1:0] srcPort;
      logic [AMI_APP_BITS-1:0]  srcApp;
      logic [AMI_SIZE_W-1:0]    size;
   } AMIResp;
endpackage

module ami_resp_buffer
   import ami_pkg::*;
#(
   parameter int unsigned NUM_APPS  = 2,
   parameter int unsigned NUM_PORTS = 2,
   parameter int unsigned LOG_DEPTH = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 mem_resp_select_valid_in [NUM_APPS][NUM_PORTS],
   input  AMIResp               mem_resp_in,
   output logic                 mem_resp_grant_out       [NUM_APPS][NUM_PORTS],
   output AMIResp               app_resp_out             [NUM_APPS][NUM_PORTS],
   input  logic                 app_resp_grant_in        [NUM_APPS][NUM_PORTS],
   output logic [LOG_DEPTH:0]   slot_count_out           [NUM_APPS][NUM_PORTS],
   output logic                 err_multi_select_out
);

   localparam int unsigned DEPTH = 1 << LOG_DEPTH;

   int unsigned sel_n;
   logic        sel_onehot;
   logic        err_q, err_d;
   AMIResp      wr_entry;

   always_comb begin
      sel_n = 0;
      for (int unsigned a = 0; a < NUM_APPS; a++) begin
         for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            sel_n = sel_n + 32'(mem_resp_select_valid_in[a][p]);
         end
      end
      sel_onehot = (sel_n == 1);
   end

   always_comb begin
      wr_entry       = mem_resp_in;
      wr_entry.valid = 1'b1;
   end

   // Any valid response without a clean one-hot select latches the error until reset.
   always_comb begin
      err_d = err_q | (mem_resp_in.valid & ~sel_onehot);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err_multi_select_out = err_q;

   for (genvar a = 0; a < NUM_APPS; a++) begin : g_app
      for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
         AMIResp               mem_q [DEPTH];
         logic [LOG_DEPTH-1:0] wptr_q, wptr_d;
         logic [LOG_DEPTH-1:0] rptr_q, rptr_d;
         logic [LOG_DEPTH:0]   cnt_q, cnt_d;
         logic                 full, empty, enq, deq;

         assign full  = (cnt_q == (LOG_DEPTH+1)'(DEPTH));
         assign empty = (cnt_q == '0);
         // Full slots refuse even when draining this cycle: no enqueue bypass.
         assign enq   = mem_resp_in.valid & mem_resp_select_valid_in[a][p] & ~full & sel_onehot;
         assign deq   = ~empty & app_resp_grant_in[a][p];

         always_comb begin
            wptr_d = wptr_q;
            rptr_d = rptr_q;
            cnt_d  = cnt_q;
            if (enq) wptr_d = wptr_q + LOG_DEPTH'(1);
            if (deq) rptr_d = rptr_q + LOG_DEPTH'(1);
            unique case ({enq, deq})
               2'b10:   cnt_d = cnt_q + (LOG_DEPTH+1)'(1);
               2'b01:   cnt_d = cnt_q - (LOG_DEPTH+1)'(1);
               default: cnt_d = cnt_q;
            endcase
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               wptr_q <= '0;
               rptr_q <= '0;
               cnt_q  <= '0;
            end else begin
               wptr_q <= wptr_d;
               rptr_q <= rptr_d;
               cnt_q  <= cnt_d;
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int unsigned i = 0; i < DEPTH; i++) begin
                  mem_q[i] <= '0;
               end
            end else if (enq) begin
               mem_q[wptr_q] <= wr_entry;
            end
         end

         assign mem_resp_grant_out[a][p] = enq;
         assign app_resp_out[a][p]       = empty ? '0 : mem_q[rptr_q];
         assign slot_count_out[a][p]     = cnt_q;
      end
   end

endmodule

// File: tb/tb_ami_resp_buffer.sv
// Directed bench for ami_resp_buffer: reset, single transfer, fill/wrap,
// concurrent push/pop, slot isolation, select error and asynchronous reset.

module tb_ami_resp_buffer;
   import ami_pkg::*;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         sel      [2][2];
   AMIResp       mem_resp;
   logic         mgrant   [2][2];
   AMIResp       app_resp [2][2];
   logic         agrant   [2][2];
   logic [2:0]   cnt      [2][2];
   logic         err;

   int n_cmp = 0;
   int n_err = 0;

   ami_resp_buffer #(.NUM_APPS(2), .NUM_PORTS(2), .LOG_DEPTH(2)) dut (
      .clk                      (clk),
      .rst_n                    (rst_n),
      .mem_resp_select_valid_in (sel),
      .mem_resp_in              (mem_resp),
      .mem_resp_grant_out       (mgrant),
      .app_resp_out             (app_resp),
      .app_resp_grant_in        (agrant),
      .slot_count_out           (cnt),
      .err_multi_select_out     (err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] gvec();
      return {mgrant[1][1], mgrant[1][0], mgrant[0][1], mgrant[0][0]};
   endfunction

   task automatic clr_in();
      mem_resp = '0;
      for (int a = 0; a < 2; a++) begin
         for (int p = 0; p < 2; p++) begin
            sel[a][p] = 1'b0;
         end
      end
   endtask

   task automatic clr_grant();
      for (int a = 0; a < 2; a++) begin
         for (int p = 0; p < 2; p++) begin
            agrant[a][p] = 1'b0;
         end
      end
   endtask

   task automatic send(input int a, input int p, input logic [63:0] d);
      clr_in();
      mem_resp.valid   = 1'b1;
      mem_resp.data    = d;
      mem_resp.srcApp  = 1'(a);
      mem_resp.srcPort = 1'(p);
      mem_resp.size    = 6'd8;
      sel[a][p]        = 1'b1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic chk_all_idle(input string tag);
      for (int a = 0; a < 2; a++) begin
         for (int p = 0; p < 2; p++) begin
            chk({tag, "_valid"}, 64'(app_resp[a][p].valid), 64'(0));
            chk({tag, "_count"}, 64'(cnt[a][p]), 64'(0));
         end
      end
      chk({tag, "_err"}, 64'(err), 64'(0));
      chk({tag, "_grants"}, 64'(gvec()), 64'(0));
   endtask

   initial begin
      clr_in();
      clr_grant();

      // 1: reset then idle
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      settle();
      chk_all_idle("reset_idle");

      // 2: single response to [1][0]
      send(1, 0, 64'hA5);
      settle();
      chk("single_grant", 64'(gvec()), 64'(4'b0100));
      chk("single_head_before", 64'(app_resp[1][0].valid), 64'(0));
      tick();
      clr_in();
      settle();
      chk("single_valid", 64'(app_resp[1][0].valid), 64'(1));
      chk("single_data", app_resp[1][0].data, 64'hA5);
      chk("single_count", 64'(cnt[1][0]), 64'(1));
      agrant[1][0] = 1'b1;
      tick();
      clr_grant();
      settle();
      chk("single_pop_valid", 64'(app_resp[1][0].valid), 64'(0));
      chk("single_pop_count", 64'(cnt[1][0]), 64'(0));
      agrant[1][0] = 1'b1;
      tick();
      clr_grant();
      settle();
      chk("underflow_count", 64'(cnt[1][0]), 64'(0));

      // 3: fill and wrap on [0][1]
      for (int i = 1; i <= 5; i++) begin
         send(0, 1, 64'(i));
         settle();
         chk("fill_grant", 64'(mgrant[0][1]), (i <= 4) ? 64'(1) : 64'(0));
         tick();
      end
      clr_in();
      settle();
      chk("fill_count", 64'(cnt[0][1]), 64'(4));
      chk("fill_head", app_resp[0][1].data, 64'(1));
      agrant[0][1] = 1'b1;
      for (int i = 1; i <= 2; i++) begin
         settle();
         chk("wrap_pop_a", app_resp[0][1].data, 64'(i));
         tick();
      end
      clr_grant();
      for (int i = 6; i <= 7; i++) begin
         send(0, 1, 64'(i));
         settle();
         chk("wrap_push_grant", 64'(mgrant[0][1]), 64'(1));
         tick();
      end
      clr_in();
      settle();
      chk("wrap_count", 64'(cnt[0][1]), 64'(4));
      agrant[0][1] = 1'b1;
      begin
         logic [63:0] exp_seq [4];
         exp_seq = '{64'd3, 64'd4, 64'd6, 64'd7};
         for (int i = 0; i < 4; i++) begin
            settle();
            chk("wrap_pop_b_valid", 64'(app_resp[0][1].valid), 64'(1));
            chk("wrap_pop_b_data", app_resp[0][1].data, exp_seq[i]);
            tick();
         end
      end
      clr_grant();
      settle();
      chk("wrap_drained", 64'(cnt[0][1]), 64'(0));

      // 4: simultaneous enq/deq on [0][0]
      send(0, 0, 64'd10);
      tick();
      send(0, 0, 64'd11);
      tick();
      clr_in();
      settle();
      chk("sim_pre_count", 64'(cnt[0][0]), 64'(2));
      agrant[0][0] = 1'b1;
      for (int k = 0; k < 5; k++) begin
         send(0, 0, 64'(12 + k));
         settle();
         chk("sim_grant", 64'(mgrant[0][0]), 64'(1));
         chk("sim_count", 64'(cnt[0][0]), 64'(2));
         chk("sim_head", app_resp[0][0].data, 64'(10 + k));
         tick();
      end
      clr_in();
      clr_grant();
      settle();
      chk("sim_post_count", 64'(cnt[0][0]), 64'(2));
      chk("sim_post_head", app_resp[0][0].data, 64'd15);
      send(0, 0, 64'd17);
      tick();
      send(0, 0, 64'd18);
      tick();
      clr_in();
      settle();
      chk("sim_full_count", 64'(cnt[0][0]), 64'(4));
      send(0, 0, 64'd19);
      agrant[0][0] = 1'b1;
      settle();
      chk("full_no_bypass_grant", 64'(mgrant[0][0]), 64'(0));
      tick();
      clr_in();
      settle();
      chk("full_no_bypass_count", 64'(cnt[0][0]), 64'(3));
      begin
         logic [63:0] rest [3];
         rest = '{64'd16, 64'd17, 64'd18};
         for (int i = 0; i < 3; i++) begin
            settle();
            chk("sim_drain", app_resp[0][0].data, rest[i]);
            tick();
         end
      end
      clr_grant();
      settle();
      chk("sim_drained", 64'(cnt[0][0]), 64'(0));

      // 5: isolation - [1][1] full, [0][0] keeps accepting
      for (int i = 0; i < 4; i++) begin
         send(1, 1, 64'(20 + i));
         tick();
      end
      for (int k = 0; k < 3; k++) begin
         send(0, 0, 64'(30 + k));
         settle();
         chk("iso_grant00", 64'(gvec()), 64'(4'b0001));
         tick();
         send(1, 1, 64'(40 + k));
         settle();
         chk("iso_grant11", 64'(gvec()), 64'(4'b0000));
         tick();
      end
      clr_in();
      settle();
      chk("iso_count11", 64'(cnt[1][1]), 64'(4));
      chk("iso_count00", 64'(cnt[0][0]), 64'(3));
      chk("iso_head11", app_resp[1][1].data, 64'd20);
      chk("iso_err_clean", 64'(err), 64'(0));

      // 6: multi-select error, sticky, async reset mid-cycle
      send(0, 0, 64'hDEAD);
      sel[1][0] = 1'b1;
      settle();
      chk("multi_grant", 64'(gvec()), 64'(0));
      chk("multi_err_before_edge", 64'(err), 64'(0));
      tick();
      clr_in();
      settle();
      chk("multi_err", 64'(err), 64'(1));
      chk("multi_no_enq", 64'(cnt[0][0]), 64'(3));
      tick();
      tick();
      chk("multi_err_sticky", 64'(err), 64'(1));
      rst_n = 1'b0;
      #1;
      chk("async_valid00", 64'(app_resp[0][0].valid), 64'(0));
      chk("async_count00", 64'(cnt[0][0]), 64'(0));
      chk("async_valid11", 64'(app_resp[1][1].valid), 64'(0));
      chk("async_count11", 64'(cnt[1][1]), 64'(0));
      chk("async_err", 64'(err), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      settle();
      chk_all_idle("post_reset");

      // zero-bit select with valid also flags the error
      clr_in();
      mem_resp.valid = 1'b1;
      mem_resp.data  = 64'h55;
      settle();
      chk("zero_sel_grant", 64'(gvec()), 64'(0));
      tick();
      clr_in();
      settle();
      chk("zero_sel_err", 64'(err), 64'(1));

      // valid low: no grant, no enqueue regardless of select
      sel[1][1] = 1'b1;
      mem_resp.data = 64'h77;
      settle();
      chk("invalid_grant", 64'(gvec()), 64'(0));
      tick();
      clr_in();
      settle();
      chk("invalid_count", 64'(cnt[1][1]), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
